// File: rtl/apb_req_master_if.sv
// rtl/apb_req_master_if.sv - APB bus bundle between apb_req_master and its slave
interface apb_req_master_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - single-outstanding request/response to APB master with wait timeout
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    apb_req_master_if.master          apb
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_e                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      tmo_q, tmo_d;
    logic [7:0]                cnt_q, cnt_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ready_q && req_valid_i) begin
                    state_d = SETUP;
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_write_i ? req_wdata_i : 32'h0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                // Completion is checked first so PREADY wins over a coincident expiry.
                if (apb.PREADY) begin
                    state_d = RESP;
                    err_d   = apb.PSLVERR;
                    rdata_d = write_q ? 32'h0 : apb.PRDATA;
                    tmo_d   = 1'b0;
                end else if ((TMO != 8'd0) && (cnt_q == TMO)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    tmo_d   = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so req_ready_o stays low throughout reset.
        ready_d = (state_d == IDLE);
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;

    assign apb.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb.PENABLE = (state_q == ACCESS);
    assign apb.PADDR   = addr_q;
    assign apb.PWRITE  = write_q;
    assign apb.PWDATA  = wdata_q;

endmodule
